ram_uart_ctrl: RTL and testbench
================================

Name: ram_uart_ctrl

Overview:
- Parametrised, multi-cycle bus controller for the shared SRAM1/UART data bus.
- Replaces clock-phase strobe gating with a registered FSM. Strobe width is a parameter (WAIT_CYC) and bus turnaround is explicit.
- UART accesses wait for the UART to be ready, with a timeout.
- Sits between the CPU memory stage (req/ack handshake) and the board pins.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, data bus width.
- WAIT_CYC, 1, extra strobe-active cycles per access (strobe width = WAIT_CYC+1 cycles); range 0..15.
- UART_DATA_ADDR, 16'hBF00, UART data register address (compared on addr_i[15:0]).
- UART_STAT_ADDR, 16'hBF01, UART status register address.
- TIMEOUT, 1023, maximum cycles spent waiting for UART ready before an error ack.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_i  in  1  access request; sampled only in IDLE.
- we_i  in  1  1 = write, 0 = read; latched on accept.
- addr_i  in  ADDR_W  access address; latched on accept.
- wdata_i  in  DATA_W  write data; latched on accept.
- rdata_o  out  DATA_W  read result; valid while ack_o=1 and held until the next ack.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies ack_o; 1 = UART timeout.
- busy_o  out  1  1 from the accept cycle+1 through the ack cycle.
- ram_addr_o  out  ADDR_W  SRAM address, registered.
- ram_data_io  inout  DATA_W  shared SRAM/UART data bus.
- ram_en_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  SRAM chip enable, output enable, write enable; active-low and registered.
- rdn_o, wrn_o  out  1 each  UART read and write strobes; active-low and registered.
- data_ready_i, tbre_i, tsre_i  in  1 each  UART status inputs.

Behaviour:
- Reset values:
  - All active-low strobes = 1; ram_data_io = Z.
  - ack_o = err_o = busy_o = 0; rdata_o = 0; ram_addr_o = 0.
  - FSM = IDLE.
  - Reset asserted mid-access deasserts strobes and releases the bus immediately, with no completion ack.
- FSM states: IDLE, WAIT_RDY, STROBE, HOLD, DONE.
- Decode is latched at accept:
  - STAT = addr[15:0] == UART_STAT_ADDR.
  - UDAT = addr[15:0] == UART_DATA_ADDR.
  - SRAM = everything else.
- IDLE with req_i=1 → latch we, addr, wdata, then:
  - STAT → DONE. Read: rdata = {0…, data_ready_i, tbre_i & tsre_i}, sampled in DONE. Write: ignored, acked.
  - SRAM → STROBE, with counter = WAIT_CYC.
  - UDAT → WAIT_RDY.
- WAIT_RDY:
  - Ready condition: read requires data_ready_i=1; write requires tbre_i & tsre_i = 1.
  - Ready → STROBE, counter = WAIT_CYC.
  - After TIMEOUT cycles without ready → DONE with err=1 and rdata = 0.
- STROBE:
  - SRAM: en_n=0 plus oe_n=0 (read) or we_n=0 (write). UART: rdn=0 (read) or wrn=0 (write).
  - Counter decrements each cycle; at 0 → HOLD.
  - Reads capture ram_data_io on the edge leaving STROBE.
- HOLD:
  - All strobes deasserted; en_n stays 0 for SRAM.
  - Write data is still driven, giving one cycle of data hold after the strobe rises.
  - → DONE.
- DONE: ack_o=1, en_n=1, bus Z → IDLE.
- Bus drive: ram_data_io is driven with latched wdata only for writes in STROBE and HOLD; Z otherwise, including in IDLE.
- Latency from accept edge to the ack cycle:
  - SRAM: WAIT_CYC+3 cycles.
  - UART: the same plus the wait time.
  - STAT: 1 cycle.
- req_i in any state other than IDLE is ignored. Back-to-back accesses: req_i may be held high; the next accept occurs in the IDLE cycle after DONE.
- we_i with an SRAM address is never mixed with the UART strobes, and vice versa. At most one active-low strobe pin is low in any cycle, excluding en_n.
- Counter widths: wait counter 4 bits; timeout counter clog2(TIMEOUT+1) bits.

Decomposition:
- Package ram_uart_pkg holds:
  - the state enum;
  - the decode-kind enum (SRAM, UDAT, STAT);
  - default address constants;
  - the status bit positions (bit1 = data_ready, bit0 = tx_empty).
- One sub-module, access_timer: loadable down-counter with a zero flag, used for both the strobe width and the timeout. Instanced twice.

Test Plan:
- WAIT_CYC=1; SRAM write addr 0x00123, data 0xBEEF → we_n low for exactly 2 cycles, bus driven through HOLD, ack at accept+4, busy_o high 4 cycles.
- SRAM read addr 0x00123 with the bus model returning 0xBEEF → oe_n low 2 cycles, rdata_o=0xBEEF at ack, bus Z from the bench side throughout.
- Status read at 0xBF01 with data_ready=1, tbre=1, tsre=0 → ack next cycle, rdata=0x0002, no strobe toggles.
- UART write to 0xBF00 with tsre=0 for 20 cycles, then 1 → wrn stays 1 during the wait, then low for WAIT_CYC+1 cycles, ack with err=0.
- UART read with TIMEOUT=15 and data_ready held at 0 → ack with err=1 and rdata=0 after 15 wait cycles, rdn never low.
- Assert rst during SRAM write STROBE → we_n=1, en_n=1, bus Z in the same cycle, no ack. The next request after reset completes normally.

Source files
------------

// File: rtl/ram_uart_pkg.sv
// Shared types and constants for the SRAM1/UART bus controller.
//   state_t  : controller FSM states
//   kind_t   : access target decoded from the low 16 address bits
//   DEF_*    : default UART register addresses
//   STAT_*   : bit positions inside the UART status word
package ram_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    KIND_SRAM,
    KIND_UDAT,
    KIND_STAT
  } kind_t;

  localparam logic [15:0] DEF_UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] DEF_UART_STAT_ADDR = 16'hBF01;

  // Status word layout: bit1 = receive data ready, bit0 = transmitter empty.
  localparam int STAT_DATA_READY_BIT = 1;
  localparam int STAT_TX_EMPTY_BIT   = 0;

  // Anything that is not one of the two UART registers goes to SRAM.
  function automatic kind_t decode_kind(input logic [15:0] addr,
                                        input logic [15:0] data_addr,
                                        input logic [15:0] stat_addr);
    if (addr == stat_addr)      return KIND_STAT;
    else if (addr == data_addr) return KIND_UDAT;
    else                        return KIND_SRAM;
  endfunction

endpackage

// File: rtl/ram_uart_ctrl_access_timer.sv
// access_timer: loadable down-counter with a zero flag.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module access_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ram_uart_ctrl.sv
// ram_uart_ctrl: multi-cycle controller for the shared SRAM1/UART data bus.
//   clk, rst                   : clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i  : CPU request, sampled only in IDLE
//   rdata_o/ack_o/err_o/busy_o : CPU completion; err_o flags a UART timeout
//   ram_addr_o, ram_data_io    : SRAM address and shared data bus
//   ram_en_n_o/oe_n/we_n       : SRAM strobes (active-low, registered)
//   rdn_o, wrn_o               : UART strobes (active-low, registered)
//   data_ready_i/tbre_i/tsre_i : UART status inputs
module ram_uart_ctrl
  import ram_uart_pkg::*;
#(
  parameter int          ADDR_W         = 18,
  parameter int          DATA_W         = 16,
  parameter int          WAIT_CYC       = 1,
  parameter logic [15:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR,
  parameter int          TIMEOUT        = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  inout  wire  [DATA_W-1:0] ram_data_io,
  output logic              ram_en_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o,
  output logic              rdn_o,
  output logic              wrn_o,
  input  logic              data_ready_i,
  input  logic              tbre_i,
  input  logic              tsre_i
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The wait state is entered on the accept edge, so loading TIMEOUT-1
  // gives exactly TIMEOUT WAIT_RDY cycles before giving up.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]      WT_LOAD = 4'(WAIT_CYC);

  state_t            state_reg, state_next;
  kind_t             kind_reg, kind_next, acc_kind;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg, cap_reg, rdata_reg, stat_word;
  logic              ack_reg, err_reg, busy_reg, drive_reg;
  logic              en_n_reg, oe_n_reg, we_n_reg, rdn_reg, wrn_reg;
  logic              accept, timeout_hit, uart_ready;
  logic              wt_load, wt_dec, wt_zero;
  logic              to_load, to_dec, to_zero;
  logic              sram_next, udat_next, strobe_next, active_next;

  access_timer #(.W(4)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (wt_load),
    .load_val (WT_LOAD),
    .dec      (wt_dec),
    .zero     (wt_zero)
  );

  access_timer #(.W(TO_W)) u_timeout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_LOAD),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  always_comb begin
    stat_word                      = '0;
    stat_word[STAT_DATA_READY_BIT] = data_ready_i;
    stat_word[STAT_TX_EMPTY_BIT]   = tbre_i & tsre_i;
  end

  assign acc_kind   = decode_kind(addr_i[15:0], UART_DATA_ADDR, UART_STAT_ADDR);
  assign uart_ready = we_reg ? (tbre_i & tsre_i) : data_ready_i;

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    wt_load     = 1'b0;
    wt_dec      = 1'b0;
    to_load     = 1'b0;
    to_dec      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          case (acc_kind)
            KIND_STAT: state_next = ST_DONE;
            KIND_UDAT: begin
              state_next = ST_WAIT_RDY;
              to_load    = 1'b1;
            end
            default: begin
              state_next = ST_STROBE;
              wt_load    = 1'b1;
            end
          endcase
        end
      end
      ST_WAIT_RDY: begin
        // Ready wins over timeout in the last wait cycle.
        if (uart_ready) begin
          state_next = ST_STROBE;
          wt_load    = 1'b1;
        end else if (to_zero) begin
          state_next  = ST_DONE;
          timeout_hit = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (wt_zero) state_next = ST_HOLD;
        else         wt_dec     = 1'b1;
      end
      ST_HOLD: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Pin registers are computed from the upcoming state so that every strobe
  // lines up exactly with the FSM state it belongs to.
  assign kind_next   = accept ? acc_kind : kind_reg;
  assign we_next     = accept ? we_i : we_reg;
  assign sram_next   = (kind_next == KIND_SRAM);
  assign udat_next   = (kind_next == KIND_UDAT);
  assign strobe_next = (state_next == ST_STROBE);
  assign active_next = strobe_next || (state_next == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      kind_reg  <= KIND_SRAM;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cap_reg   <= '0;
      rdata_reg <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      drive_reg <= 1'b0;
      en_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      rdn_reg   <= 1'b1;
      wrn_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        kind_reg  <= acc_kind;
        we_reg    <= we_i;
        addr_reg  <= addr_i;
        wdata_reg <= wdata_i;
      end
      // Read data is taken on the edge that ends the strobe.
      if ((state_reg == ST_STROBE) && wt_zero) cap_reg <= ram_data_io;
      // rdata only changes on entry to DONE, so it holds between acks.
      if (state_next == ST_DONE) begin
        if (timeout_hit)              rdata_reg <= '0;
        else if (accept && !we_i)     rdata_reg <= stat_word;
        else if ((state_reg == ST_HOLD) && !we_reg) rdata_reg <= cap_reg;
      end
      ack_reg   <= (state_next == ST_DONE);
      err_reg   <= timeout_hit;
      busy_reg  <= (state_next != ST_IDLE);
      drive_reg <= we_next && active_next;
      en_n_reg  <= !(sram_next && active_next);
      oe_n_reg  <= !(sram_next && strobe_next && !we_next);
      we_n_reg  <= !(sram_next && strobe_next && we_next);
      rdn_reg   <= !(udat_next && strobe_next && !we_next);
      wrn_reg   <= !(udat_next && strobe_next && we_next);
    end
  end

  assign ram_data_io = drive_reg ? wdata_reg : {DATA_W{1'bz}};
  assign rdata_o     = rdata_reg;
  assign ack_o       = ack_reg;
  assign err_o       = err_reg;
  assign busy_o      = busy_reg;
  assign ram_addr_o  = addr_reg;
  assign ram_en_n_o  = en_n_reg;
  assign ram_oe_n_o  = oe_n_reg;
  assign ram_we_n_o  = we_n_reg;
  assign rdn_o       = rdn_reg;
  assign wrn_o       = wrn_reg;

endmodule

// File: tb/tb_ram_uart_ctrl.sv
// Testbench for ram_uart_ctrl. A per-cycle expectation timeline is built
// from the access latency rules for each request; one compare process checks
// every pin against it on the falling edge. Literal per-access expectations
// (latency, read data, error flag, strobe cycles) pin the timeline model.
module tb_ram_uart_ctrl;

  localparam int WAIT_CYC   = 1;
  localparam int TB_TIMEOUT = 25;
  localparam int NC         = 1024;

  logic        clk, rst, req_i, we_i;
  logic [17:0] addr_i, ram_addr_o;
  logic [15:0] wdata_i, rdata_o;
  logic        ack_o, err_o, busy_o;
  logic        ram_en_n_o, ram_oe_n_o, ram_we_n_o, rdn_o, wrn_o;
  logic        data_ready_i, tbre_i, tsre_i;
  wire  [15:0] ram_bus;

  logic [15:0] sram_rd_val, uart_rd_val;

  // Board model: SRAM/UART drive the bus while their read strobe is low;
  // the undriven bus floats high through pull-ups.
  assign ram_bus = (!ram_en_n_o && !ram_oe_n_o) ? sram_rd_val :
                   (!rdn_o ? uart_rd_val : 16'hzzzz);
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
      pullup pu (ram_bus[gi]);
    end
  endgenerate

  ram_uart_ctrl #(
    .ADDR_W(18), .DATA_W(16), .WAIT_CYC(WAIT_CYC),
    .UART_DATA_ADDR(16'hBF00), .UART_STAT_ADDR(16'hBF01), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o),
    .busy_o(busy_o), .ram_addr_o(ram_addr_o), .ram_data_io(ram_bus),
    .ram_en_n_o(ram_en_n_o), .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o),
    .rdn_o(rdn_o), .wrn_o(wrn_o), .data_ready_i(data_ready_i),
    .tbre_i(tbre_i), .tsre_i(tsre_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number.
  logic        e_en_n[NC], e_oe_n[NC], e_we_n[NC], e_rdn[NC], e_wrn[NC];
  logic        e_busy[NC], e_ack[NC], e_err[NC], e_rd_upd[NC], e_addr_chk[NC];
  logic [15:0] e_bus[NC], e_rdata[NC];
  logic [17:0] e_addr[NC];

  int n_chk = 0, n_pass = 0;
  bit run_chk = 0;
  logic [15:0] m_rdata = 16'h0000;
  int ack_c, n_low;
  logic [15:0] ack_rd;
  logic ack_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
  endtask

  task automatic idle_fill(input int lo, input int hi);
    for (int i = lo; i <= hi && i < NC; i++) begin
      e_en_n[i] = 1; e_oe_n[i] = 1; e_we_n[i] = 1; e_rdn[i] = 1; e_wrn[i] = 1;
      e_busy[i] = 0; e_ack[i] = 0; e_err[i] = 0; e_rd_upd[i] = 0;
      e_addr_chk[i] = 0; e_bus[i] = 16'hFFFF; e_rdata[i] = 16'h0000;
      e_addr[i] = '0;
    end
  endtask

  // Timeline model: accept at the edge ending cycle 'base'. An access spends
  // w wait cycles (UART only), WAIT_CYC+1 strobe cycles, one hold cycle and
  // one ack cycle; a status access acks in the next cycle; a UART access with
  // no ready in TB_TIMEOUT wait cycles acks with an error in the cycle after.
  task automatic plan(input logic we, input logic [17:0] addr, input logic [15:0] wd,
                      input int rdy_at, input int base, output int len);
    int s, w, b;
    bit is_stat, is_uart, tout;
    logic [15:0] src;
    s       = WAIT_CYC + 1;
    is_stat = (addr[15:0] == 16'hBF01);
    is_uart = (addr[15:0] == 16'hBF00);
    if (is_stat) begin
      len = 1;
      e_busy[base+1] = 1;
      e_ack[base+1]  = 1;
      if (!we) begin
        e_rd_upd[base+1] = 1;
        e_rdata[base+1]  = {14'd0, data_ready_i, tbre_i & tsre_i};
      end
    end else begin
      tout = is_uart && (rdy_at < 1 || rdy_at > TB_TIMEOUT);
      w    = !is_uart ? 0 : (tout ? TB_TIMEOUT : rdy_at);
      len  = tout ? w + 1 : w + s + 2;
      for (int k = 1; k <= len; k++) e_busy[base+k] = 1;
      e_ack[base+len] = 1;
      e_err[base+len] = tout;
      if (tout) begin
        e_rd_upd[base+len] = 1;
        e_rdata[base+len]  = 16'h0000;
      end else begin
        src = is_uart ? uart_rd_val : sram_rd_val;
        for (int k = w + 1; k <= w + s; k++) begin
          b = base + k;
          if (is_uart) begin
            if (we) e_wrn[b] = 0; else e_rdn[b] = 0;
          end else begin
            e_en_n[b] = 0; e_addr_chk[b] = 1; e_addr[b] = addr;
            if (we) e_we_n[b] = 0; else e_oe_n[b] = 0;
          end
          e_bus[b] = we ? wd : src;
        end
        b = base + w + s + 1;
        if (!is_uart) begin
          e_en_n[b] = 0; e_addr_chk[b] = 1; e_addr[b] = addr;
        end
        if (we) e_bus[b] = wd;
        if (!we) begin
          e_rd_upd[base+len] = 1;
          e_rdata[base+len]  = src;
        end
      end
    end
  endtask

  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    if (run_chk && c < NC) begin
      if (rst) m_rdata = 16'h0000;
      else if (e_rd_upd[c]) m_rdata = e_rdata[c];
      chk("en_n", ram_en_n_o, e_en_n[c]);
      chk("oe_n", ram_oe_n_o, e_oe_n[c]);
      chk("we_n", ram_we_n_o, e_we_n[c]);
      chk("rdn", rdn_o, e_rdn[c]);
      chk("wrn", wrn_o, e_wrn[c]);
      chk("bus", ram_bus, e_bus[c]);
      chk("busy", busy_o, e_busy[c]);
      chk("ack", ack_o, e_ack[c]);
      chk("rdata", rdata_o, m_rdata);
      if (e_ack[c]) chk("err", err_o, e_err[c]);
      if (e_addr_chk[c]) chk("addr", ram_addr_o, e_addr[c]);
      if (!ram_oe_n_o) n_low++;
      if (!ram_we_n_o) n_low++;
      if (!rdn_o) n_low++;
      if (!wrn_o) n_low++;
      if (ack_o) begin
        ack_c   = c;
        ack_rd  = rdata_o;
        ack_err = err_o;
      end
    end
  end

  task automatic do_txn(input string tag, input logic we, input logic [17:0] addr,
                        input logic [15:0] wd, input int rdy_at, input bit hold_req,
                        input int exp_lat, input int exp_low,
                        input logic [15:0] exp_rd, input logic exp_err);
    int base, len;
    @(negedge clk);
    base = cyc;
    plan(we, addr, wd, rdy_at, base, len);
    ack_c = -1; n_low = 0;
    req_i = 1; we_i = we; addr_i = addr; wdata_i = wd;
    @(negedge clk);
    if (hold_req) addr_i = 18'h3FFFF;
    else req_i = 0;
    for (int k = 1; k <= len; k++) begin
      if (k == rdy_at) begin
        if (we) tsre_i = 1; else data_ready_i = 1;
      end
      if (k == len) req_i = 0;
      @(negedge clk);
    end
    chk({tag, "_lat"}, ack_c - base, exp_lat);
    chk({tag, "_rdata"}, ack_rd, exp_rd);
    chk({tag, "_err"}, ack_err, exp_err);
    chk({tag, "_strobes"}, n_low, exp_low);
    $display("txn %s addr=%h we=%0d lat=%0d rdata=%h err=%0d", tag, addr, we,
             ack_c - base, ack_rd, ack_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len;
    clk = 0; rst = 1; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
    data_ready_i = 0; tbre_i = 0; tsre_i = 0;
    sram_rd_val = 16'hBEEF; uart_rd_val = 16'h5A3C;
    idle_fill(0, NC - 1);
    repeat (3) @(negedge clk);
    chk("rst_en_n", ram_en_n_o, 1);
    chk("rst_oe_n", ram_oe_n_o, 1);
    chk("rst_we_n", ram_we_n_o, 1);
    chk("rst_rdn", rdn_o, 1);
    chk("rst_wrn", wrn_o, 1);
    chk("rst_bus", ram_bus, 16'hFFFF);
    chk("rst_ack", ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rdata", rdata_o, 16'h0000);
    chk("rst_addr", ram_addr_o, 18'h00000);
    rst = 0;
    run_chk = 1;

    do_txn("sram_wr", 1, 18'h00123, 16'hBEEF, 0, 0, 4, 2, 16'h0000, 0);
    do_txn("sram_rd", 0, 18'h00123, 16'h1234, 0, 1, 4, 2, 16'hBEEF, 0);
    data_ready_i = 1; tbre_i = 1; tsre_i = 0;
    do_txn("stat_rd", 0, 18'h0BF01, 16'h1234, 0, 0, 1, 0, 16'h0002, 0);
    data_ready_i = 0;
    do_txn("uart_wr_wait", 1, 18'h0BF00, 16'h0041, 21, 0, 25, 2, 16'h0002, 0);
    do_txn("uart_rd_timeout", 0, 18'h0BF00, 16'h1234, 0, 0, 26, 0, 16'h0000, 1);
    do_txn("stat_rd2", 0, 18'h0BF01, 16'h1234, 0, 0, 1, 0, 16'h0001, 0);
    do_txn("uart_rd_edge", 0, 18'h0BF00, 16'h1234, 25, 0, 29, 2, 16'h5A3C, 0);
    uart_rd_val = 16'h00A5;
    do_txn("uart_rd_fast", 0, 18'h0BF00, 16'h1234, 1, 0, 5, 2, 16'h00A5, 0);
    do_txn("stat_wr", 1, 18'h0BF01, 16'h9999, 0, 0, 1, 0, 16'h00A5, 0);
    do_txn("sram_wr_hi", 1, 18'h2ABCD, 16'h0F0F, 0, 0, 4, 2, 16'h00A5, 0);

    // Reset in the first strobe cycle of an SRAM write.
    @(negedge clk);
    base = cyc;
    plan(1, 18'h00456, 16'h1357, 0, base, len);
    ack_c = -1;
    req_i = 1; we_i = 1; addr_i = 18'h00456; wdata_i = 16'h1357;
    @(negedge clk);
    req_i = 0;
    chk("mid_we_n_low", ram_we_n_o, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_we_n", ram_we_n_o, 1);
    chk("mid_rst_en_n", ram_en_n_o, 1);
    chk("mid_rst_bus", ram_bus, 16'hFFFF);
    chk("mid_rst_busy", busy_o, 0);
    idle_fill(base + 2, base + len + 8);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_ack", ack_c, -1);
    $display("txn reset_mid_strobe addr=%h ack_seen=%0d", 18'h00456, (ack_c != -1));

    sram_rd_val = 16'hC0DE;
    do_txn("sram_rd_hi", 0, 18'h2ABCD, 16'h1234, 0, 0, 4, 2, 16'hC0DE, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
